// File: rtl/kyber_pke_encrypt.sv
// Kyber-768 PKE encryption front end: stages r, ek, m, c into a 1280-byte buffer.
// Define KYBER_PKE_DIGEST_EN to build the post-load 16-bit byte-sum digest scan.
module kyber_pke_encrypt (
  input  logic        clk,
  input  logic        reset,
  input  logic        set,
  input  logic        readin,
  input  logic        full_in,
  input  logic [3:0]  data_type,
  input  logic [7:0]  kyber_din,
  input  logic [15:0] kyber_in_index,
  output logic [3:0]  input_type,
  output logic        readin_ok,
  output logic        done,
  output logic [15:0] digest
);

  typedef enum logic [2:0] {
    S_IDLE, S_LD_R, S_LD_EK, S_LD_M, S_LD_C, S_SCAN, S_DONE
  } state_t;

  state_t      r_state;
  logic [7:0]  r_buf [0:1279];
  logic [10:0] w_base;
  logic [15:0] w_len;
  logic        w_load;
  logic        w_match;
  logic        w_wr;
  logic        w_adv;
  logic [10:0] w_addr;
`ifdef KYBER_PKE_DIGEST_EN
  logic [10:0] r_cnt;
  logic [15:0] r_acc;
`endif

  always_comb begin
    w_base = '0;
    w_len  = '0;
    w_load = 1'b0;
    case (r_state)
      S_LD_R:  begin w_base = 11'd0;    w_len = 16'd32;   w_load = 1'b1; end
      S_LD_EK: begin w_base = 11'd32;   w_len = 16'd1184; w_load = 1'b1; end
      S_LD_M:  begin w_base = 11'd1216; w_len = 16'd32;   w_load = 1'b1; end
      S_LD_C:  begin w_base = 11'd1248; w_len = 16'd32;   w_load = 1'b1; end
      default: ;
    endcase
    w_match = w_load && (data_type == input_type);
    w_wr    = set && w_match && readin && (kyber_in_index < w_len);
    w_adv   = w_match && full_in;
    w_addr  = w_base + kyber_in_index[10:0];
  end

  // Buffer survives a set-low abort; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 1280; i++) r_buf[i] <= '0;
    end else if (w_wr) begin
      r_buf[w_addr] <= kyber_din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      input_type <= '0;
      readin_ok  <= 1'b0;
      done       <= 1'b0;
      digest     <= '0;
`ifdef KYBER_PKE_DIGEST_EN
      r_cnt      <= '0;
      r_acc      <= '0;
`endif
    end else if (!set) begin
      r_state    <= S_IDLE;
      input_type <= '0;
      readin_ok  <= 1'b0;
      done       <= 1'b0;
      digest     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (readin) begin
          r_state    <= S_LD_R;
          input_type <= 4'd1;
          readin_ok  <= 1'b1;
        end
        S_LD_R:  if (w_adv) begin r_state <= S_LD_EK; input_type <= 4'd2; end
        S_LD_EK: if (w_adv) begin r_state <= S_LD_M;  input_type <= 4'd3; end
        S_LD_M:  if (w_adv) begin r_state <= S_LD_C;  input_type <= 4'd4; end
        S_LD_C: if (w_adv) begin
          input_type <= '0;
          readin_ok  <= 1'b0;
`ifdef KYBER_PKE_DIGEST_EN
          r_state    <= S_SCAN;
          r_cnt      <= '0;
          r_acc      <= '0;
`else
          r_state    <= S_DONE;
          done       <= 1'b1;
`endif
        end
`ifdef KYBER_PKE_DIGEST_EN
        S_SCAN: begin
          r_acc <= r_acc + {8'h00, r_buf[r_cnt]};
          r_cnt <= r_cnt + 11'd1;
          if (r_cnt == 11'd1279) begin
            r_state <= S_DONE;
            done    <= 1'b1;
            digest  <= r_acc + {8'h00, r_buf[r_cnt]};
          end
        end
`endif
        S_DONE:  ;
        default: begin
          r_state    <= S_IDLE;
          input_type <= '0;
          readin_ok  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kyber_pke_encrypt.sv
// Bench for kyber_pke_encrypt: directed plus $urandom loads checked against an operand/byte-array model.
module tb_kyber_pke_encrypt;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        set = 1'b0;
  logic        readin = 1'b0;
  logic        full_in = 1'b0;
  logic [3:0]  data_type = '0;
  logic [7:0]  kyber_din = '0;
  logic [15:0] kyber_in_index = '0;
  logic [3:0]  input_type;
  logic        readin_ok;
  logic        done;
  logic [15:0] digest;

  kyber_pke_encrypt dut (
    .clk(clk), .reset(reset), .set(set), .readin(readin), .full_in(full_in),
    .data_type(data_type), .kyber_din(kyber_din), .kyber_in_index(kyber_in_index),
    .input_type(input_type), .readin_ok(readin_ok), .done(done), .digest(digest)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  byte unsigned mem [1280];
  int m_type = 0;

  function automatic int base_of(input int t);
    case (t)
      1: return 0;
      2: return 32;
      3: return 1216;
      4: return 1248;
      default: return 0;
    endcase
  endfunction

  function automatic int len_of(input int t);
    case (t)
      1: return 32;
      2: return 1184;
      3: return 32;
      4: return 32;
      default: return 0;
    endcase
  endfunction

  function automatic int model_sum();
    int s = 0;
    for (int i = 0; i < 1280; i++) s += mem[i];
    return s % 65536;
  endfunction

  function automatic int exp_it();
    return (m_type >= 1 && m_type <= 4) ? m_type : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int t, input int idx, input int b, input bit rd, input bit fl);
    data_type = t[3:0]; kyber_in_index = idx[15:0]; kyber_din = b[7:0];
    readin = rd; full_in = fl;
    tick();
    if (m_type >= 1 && m_type <= 4 && t == m_type) begin
      if (rd && idx < len_of(t)) mem[base_of(t) + idx] = b[7:0];
      if (fl) m_type++;
    end
    readin = 1'b0; full_in = 1'b0;
    chk("input_type", {28'd0, input_type}, exp_it());
    chk("readin_ok", {31'd0, readin_ok}, (m_type >= 1 && m_type <= 4) ? 1 : 0);
  endtask

  task automatic start();
    set = 1'b1; readin = 1'b1;
    tick();
    readin = 1'b0;
    m_type = 1;
    chk("start_input_type", {28'd0, input_type}, 1);
    chk("start_readin_ok", {31'd0, readin_ok}, 1);
  endtask

  task automatic finish_check();
    int cyc;
`ifdef KYBER_PKE_DIGEST_EN
    chk("scan_done_low", {31'd0, done}, 0);
    cyc = 0;
    while (!done && cyc < 1400) begin
      tick();
      cyc++;
    end
    chk("done_latency", cyc, 1280);
    chk("digest", {16'd0, digest}, model_sum());
`else
    cyc = 0;
    chk("done_next_edge", {31'd0, done}, 1);
    chk("digest_zero", {16'd0, digest}, 0);
`endif
    repeat (3) tick();
    chk("done_held", {31'd0, done}, 1);
    chk("done_input_type", {28'd0, input_type}, 0);
`ifdef KYBER_PKE_DIGEST_EN
    chk("digest_held", {16'd0, digest}, model_sum());
`endif
    set = 1'b0;
    tick();
    m_type = 0;
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_input_type", {28'd0, input_type}, 0);
    chk("abort_readin_ok", {31'd0, readin_ok}, 0);
    chk("abort_digest", {16'd0, digest}, 0);
  endtask

  initial begin
    int n, typ, idx;
    for (int i = 0; i < 1280; i++) mem[i] = 8'h00;
    #12;
    chk("rst_input_type", {28'd0, input_type}, 0);
    chk("rst_readin_ok", {31'd0, readin_ok}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_digest", {16'd0, digest}, 0);
    reset = 1'b0;
    tick();
    chk("idle_no_readin", {28'd0, input_type}, 0);

    // Directed load
    start();
    for (int i = 0; i < 32; i++) put(1, i, i + 2, 1'b1, 1'b0);
    put(1, 5, 'h11, 1'b1, 1'b0);
    put(1, 5, 'h22, 1'b1, 1'b0);
    put(1, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 1184; i++) put(2, i, i % 256, 1'b1, 1'b0);
    put(2, 1200, 'hAB, 1'b1, 1'b0);
    put(2, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 32; i++) put(3, i, i + 5, 1'b1, 1'b0);
    put(4, 3, 'h99, 1'b1, 1'b1);
    put(3, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 31; i++) put(4, i, i + 7, 1'b1, 1'b0);
    put(4, 31, 38, 1'b1, 1'b1);
    finish_check();

    // Randomized load on top of the retained buffer
    start();
    for (int t = 1; t <= 4; t++) begin
      n = (t == 2) ? 300 : 40;
      for (int k = 0; k < n; k++) begin
        typ = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : t;
        idx = int'($urandom_range(0, len_of(t) + 20));
        put(typ, idx, int'($urandom_range(0, 255)), $urandom_range(0, 3) != 0, 1'b0);
      end
      put((t % 4) + 1, 0, 0, 1'b0, 1'b1);
      put(t, 0, 0, 1'b0, 1'b1);
    end
    finish_check();

    // Asynchronous reset in the middle of the ek load
    start();
    put(1, 0, 0, 1'b0, 1'b1);
    put(2, 3, 'h55, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_input_type", {28'd0, input_type}, 0);
    chk("async_rst_readin_ok", {31'd0, readin_ok}, 0);
    chk("async_rst_done", {31'd0, done}, 0);
    chk("async_rst_digest", {16'd0, digest}, 0);
    for (int i = 0; i < 1280; i++) mem[i] = 8'h00;
    m_type = 0;
    #3 reset = 1'b0;
    tick();
    start();
    for (int t = 1; t <= 4; t++) put(t, 0, 0, 1'b0, 1'b1);
    finish_check();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
